mul8_acc: RTL and testbench

Downstream accumulation stage for the 8-bit parallel multiplier. It takes the multiplier's registered, truncated 8-bit product and sums `ACC_LEN` consecutive valid products into one frame result. It also delays the operand-valid strobe by one cycle so the strobe lines up with the multiplier's one-cycle product latency. When a frame completes, the block emits a single-cycle `sum_valid_o` pulse carrying the sum and an overflow flag.

---
 rtl/mul8_acc.sv | 142 ++++++++++++++
 tb/tb_mul8_acc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul8_acc.sv
// Sums ACC_LEN consecutive valid 8-bit products into one frame result with an overflow flag.
// Sum appears two cycles after the frame's last operand; no backpressure, one product per cycle.
module mul8_acc #(
    parameter int ACC_LEN = 8,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic             clear_i,
    input  logic [7:0]       p_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             sum_valid_o,
    output logic             ovf_o,
    output logic [7:0]       cnt_o,
    output logic             busy_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    localparam int         SW       = ACC_W + 1;
    localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

    state_t           r_state;
    logic             r_v_d;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf_acc;
    logic [ACC_W-1:0] r_sum;
    logic             r_sum_vld;
    logic             r_ovf;

    state_t           w_state_nx;
    logic [ACC_W-1:0] w_acc_nx;
    logic [7:0]       w_cnt_nx;
    logic             w_ovf_acc_nx;
    logic [ACC_W-1:0] w_sum_nx;
    logic             w_sum_vld_nx;
    logic             w_ovf_nx;

    logic [ACC_W-1:0] w_p_ext;
    logic [SW-1:0]    w_add;
    logic             w_carry;

    assign w_p_ext = ACC_W'(p_i);
    assign w_add   = SW'(r_acc) + SW'(p_i);
    assign w_carry = w_add[ACC_W];

    // The strobe is delayed to line up with the multiplier's registered product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_d <= 1'b0;
        end else begin
            r_v_d <= op_valid_i & ~clear_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_sum     <= '0;
            r_sum_vld <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_acc     <= w_acc_nx;
            r_cnt     <= w_cnt_nx;
            r_ovf_acc <= w_ovf_acc_nx;
            r_sum     <= w_sum_nx;
            r_sum_vld <= w_sum_vld_nx;
            r_ovf     <= w_ovf_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_acc_nx     = r_acc;
        w_cnt_nx     = r_cnt;
        w_ovf_acc_nx = r_ovf_acc;
        w_sum_nx     = r_sum;
        w_sum_vld_nx = 1'b0;
        w_ovf_nx     = r_ovf;

        // Clear drops the partial frame but leaves the last completed result visible.
        if (clear_i) begin
            w_state_nx   = S_IDLE;
            w_acc_nx     = '0;
            w_cnt_nx     = '0;
            w_ovf_acc_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_v_d) begin
                        if (ACC_LEN == 1) begin
                            w_sum_nx     = w_p_ext;
                            w_sum_vld_nx = 1'b1;
                            w_ovf_nx     = 1'b0;
                        end else begin
                            w_acc_nx     = w_p_ext;
                            w_cnt_nx     = 8'd1;
                            w_ovf_acc_nx = 1'b0;
                            w_state_nx   = S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (r_v_d) begin
                        if (r_cnt == LAST_CNT) begin
                            w_sum_nx     = w_add[ACC_W-1:0];
                            w_ovf_nx     = r_ovf_acc | w_carry;
                            w_sum_vld_nx = 1'b1;
                            w_acc_nx     = '0;
                            w_cnt_nx     = '0;
                            w_ovf_acc_nx = 1'b0;
                            w_state_nx   = S_IDLE;
                        end else begin
                            w_acc_nx     = w_add[ACC_W-1:0];
                            w_cnt_nx     = r_cnt + 8'd1;
                            w_ovf_acc_nx = r_ovf_acc | w_carry;
                        end
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign sum_o       = r_sum;
    assign sum_valid_o = r_sum_vld;
    assign ovf_o       = r_ovf;
    assign cnt_o       = r_cnt;
    assign busy_o      = (r_state == S_ACC);

endmodule

// File: tb/tb_mul8_acc.sv
// Directed bench for mul8_acc: one instance per parameter set, fed by a registered 8-bit multiplier.
module tb_mul8_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       clear;
    logic [7:0] a, b, p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Upstream multiplier: product of cycle-t operands appears on p in cycle t+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p <= '0;
        else     p <= a * b;
    end

    logic [15:0] s4;  logic v4, o4, y4;  logic [7:0] c4;
    logic [15:0] s2;  logic v2, o2, y2;  logic [7:0] c2;
    logic [7:0]  s2n; logic v2n, o2n, y2n; logic [7:0] c2n;
    logic [15:0] s1;  logic v1, o1, y1;  logic [7:0] c1;
    logic [15:0] s8;  logic v8, o8, y8;  logic [7:0] c8;

    mul8_acc #(.ACC_LEN(4), .ACC_W(16)) u_a4 (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .clear_i(clear), .p_i(p),
        .sum_o(s4), .sum_valid_o(v4), .ovf_o(o4), .cnt_o(c4), .busy_o(y4));
    mul8_acc #(.ACC_LEN(2), .ACC_W(16)) u_a2 (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .clear_i(clear), .p_i(p),
        .sum_o(s2), .sum_valid_o(v2), .ovf_o(o2), .cnt_o(c2), .busy_o(y2));
    mul8_acc #(.ACC_LEN(2), .ACC_W(8)) u_a2w8 (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .clear_i(clear), .p_i(p),
        .sum_o(s2n), .sum_valid_o(v2n), .ovf_o(o2n), .cnt_o(c2n), .busy_o(y2n));
    mul8_acc #(.ACC_LEN(1), .ACC_W(16)) u_a1 (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .clear_i(clear), .p_i(p),
        .sum_o(s1), .sum_valid_o(v1), .ovf_o(o1), .cnt_o(c1), .busy_o(y1));
    mul8_acc u_a8 (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .clear_i(clear), .p_i(p),
        .sum_o(s8), .sum_valid_o(v8), .ovf_o(o8), .cnt_o(c8), .busy_o(y8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs, then land 1 time unit past the next rising edge.
    task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib, input logic c);
        op_valid = v;
        a        = ia;
        b        = ib;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        op_valid = 1'b0;
        clear    = 1'b0;
        #3;
        rst      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; clear = 1'b0; a = '0; b = '0;
        #12;
        check("rst_sum",  32'(s4), 0);
        check("rst_vld",  32'(v4), 0);
        check("rst_ovf",  32'(o4), 0);
        check("rst_cnt",  32'(c4), 0);
        check("rst_busy", 32'(y4), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame of four contiguous products on ACC_LEN=4: 15+14+100+1 = 130.
        drive(1, 3, 5, 0);
        drive(1, 2, 7, 0);
        check("t1_busy_c2", 32'(y4), 1);
        check("t1_cnt_c2",  32'(c4), 1);
        drive(1, 10, 10, 0);
        check("t1_busy_c3", 32'(y4), 1);
        check("t1_cnt_c3",  32'(c4), 2);
        drive(1, 1, 1, 0);
        check("t1_busy_c4", 32'(y4), 1);
        check("t1_vld_c4",  32'(v4), 0);
        check("t1_cnt_c4",  32'(c4), 3);
        idle();
        check("t1_vld_c5",  32'(v4), 1);
        check("t1_sum_c5",  32'(s4), 130);
        check("t1_ovf_c5",  32'(o4), 0);
        check("t1_cnt_c5",  32'(c4), 0);
        idle();
        check("t1_vld_c6",  32'(v4), 0);
        check("t1_busy_c6", 32'(y4), 0);
        check("t1_sum_hold", 32'(s4), 130);

        // Clear arrives with the fourth operand: partial frame dropped, old sum kept.
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        check("t4_cnt_pre", 32'(c4), 2);
        drive(1, 1, 1, 1);
        check("t4_cnt_clr",  32'(c4), 0);
        check("t4_busy_clr", 32'(y4), 0);
        check("t4_vld_clr",  32'(v4), 0);
        idle();
        check("t4_vld_after", 32'(v4), 0);
        check("t4_cnt_after", 32'(c4), 0);
        check("t4_sum_kept",  32'(s4), 130);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        check("t4_sum_still", 32'(s4), 130);
        check("t4_vld_early", 32'(v4), 0);
        idle();
        check("t4_vld", 32'(v4), 1);
        check("t4_sum", 32'(s4), 4);

        // ACC_LEN=2 with a three-cycle gap: 400 mod 256 = 144, plus 3.
        do_reset();
        drive(1, 20, 20, 0);
        check("t2_cnt_c1", 32'(c2), 0);
        idle();
        check("t2_cnt_gap1", 32'(c2), 1);
        check("t2_busy_gap", 32'(y2), 1);
        idle();
        check("t2_cnt_gap2", 32'(c2), 1);
        idle();
        check("t2_cnt_gap3", 32'(c2), 1);
        drive(1, 1, 3, 0);
        check("t2_vld_early", 32'(v2), 0);
        idle();
        check("t2_vld", 32'(v2), 1);
        check("t2_sum", 32'(s2), 147);
        check("t2_ovf", 32'(o2), 0);

        // ACC_W=8 overflow (200+100 wraps to 44), then a back-to-back frame of 1+1.
        do_reset();
        drive(1, 200, 1, 0);
        drive(1, 100, 1, 0);
        drive(1, 1, 1, 0);
        check("t3_vld1", 32'(v2n), 1);
        check("t3_sum1", 32'(s2n), 44);
        check("t3_ovf1", 32'(o2n), 1);
        drive(1, 1, 1, 0);
        check("t3_vld_gap", 32'(v2n), 0);
        check("t3_cnt_mid", 32'(c2n), 1);
        idle();
        check("t3_vld2", 32'(v2n), 1);
        check("t3_sum2", 32'(s2n), 2);
        check("t3_ovf2", 32'(o2n), 0);

        // ACC_LEN=1: every product is its own frame, pulses back to back.
        do_reset();
        drive(1, 2, 3, 0);
        drive(1, 4, 4, 0);
        check("t5_vld_a", 32'(v1), 1);
        check("t5_sum_a", 32'(s1), 6);
        idle();
        check("t5_vld_b", 32'(v1), 1);
        check("t5_sum_b", 32'(s1), 16);
        idle();
        check("t5_vld_c", 32'(v1), 0);
        check("t5_sum_c", 32'(s1), 16);

        // Asynchronous reset mid-frame, then a full default frame of eight ones.
        do_reset();
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        idle();
        check("t6_cnt_pre",  32'(c8), 3);
        check("t6_busy_pre", 32'(y8), 1);
        check("t6_s1_pre",   32'(s1), 1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_cnt",  32'(c8), 0);
        check("t6_rst_busy", 32'(y8), 0);
        check("t6_rst_sum",  32'(s8), 0);
        check("t6_rst_vld",  32'(v8), 0);
        check("t6_rst_ovf",  32'(o8), 0);
        check("t6_rst_s1",   32'(s1), 0);
        check("t6_rst_v1",   32'(v1), 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) drive(1, 1, 1, 0);
        check("t6_vld_early", 32'(v8), 0);
        idle();
        check("t6_vld", 32'(v8), 1);
        check("t6_sum", 32'(s8), 8);
        check("t6_ovf", 32'(o8), 0);
        idle();
        check("t6_vld_off",  32'(v8), 0);
        check("t6_sum_hold", 32'(s8), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
